// File: rtl/mig_app_bram_model.sv
// mig_app_bram_model: MIG 7-series app_* responder backed by block RAM.
// Build option MIG_MODEL_STALL_EN adds LFSR-driven ready stalls.
module mig_app_bram_model #(
  parameter int ADDR_WIDTH     = 28,
  parameter int DATA_WIDTH     = 128,
  parameter int MASK_WIDTH     = 16,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 4,
  parameter int CALIB_CYCLES   = 64
) (
  input  logic                  ui_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  init_calib_complete
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int IW    = MEM_DEPTH_LOG2;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int RL    = READ_LATENCY;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef logic [IW-1:0] idx_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] calib_cnt_q, calib_cnt_d;
  logic          calib_q, calib_d;

  logic pend_q, pend_d;
  idx_t pend_idx_q, pend_idx_d;

  logic [1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [1:0][MASK_WIDTH-1:0] fifo_mask_q, fifo_mask_d;
  logic                       fifo_wp_q, fifo_wp_d;
  logic                       fifo_rp_q, fifo_rp_d;
  logic [1:0]                 fifo_cnt_q, fifo_cnt_d;

  logic [RL-1:0]                 pipe_v_q, pipe_v_d;
  logic [RL-1:0][DATA_WIDTH-1:0] pipe_dat_q, pipe_dat_d;
  logic [RL:0]                   src_v;
  logic [RL:0][DATA_WIDTH-1:0]   src_dat;

  logic cmd_stall, wdf_stall;
  logic cmd_acc, wdf_acc;
  logic wr_cmd, rd_cmd;
  logic fifo_empty;
  logic push, pop;
  idx_t cmd_idx, wr_idx;
  logic wr_en;

  logic [DATA_WIDTH-1:0] wr_data, head_data, rd_word;
  logic [MASK_WIDTH-1:0] wr_mask, head_mask;

`ifdef MIG_MODEL_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR free-runs once calibrated.
  always_comb begin
    lfsr_d = lfsr_q;
    if (calib_q) begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  // LFSR state register.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign cmd_stall = (lfsr_q[1:0] == 2'b00);
  assign wdf_stall = (lfsr_q[3:2] == 2'b00);
`else
  assign cmd_stall = 1'b0;
  assign wdf_stall = 1'b0;
`endif

  assign app_rdy     = calib_q & ~pend_q & ~cmd_stall;
  assign app_wdf_rdy = calib_q & (fifo_cnt_q != 2'd2)
                     & ~wdf_stall;

  assign cmd_acc    = app_en & app_rdy;
  assign wdf_acc    = app_wdf_wren & app_wdf_rdy;
  assign wr_cmd     = cmd_acc & (app_cmd == CMD_WR);
  assign rd_cmd     = cmd_acc & (app_cmd == CMD_RD);
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign cmd_idx    = app_addr[IW+3:4];
  assign head_data  = fifo_data_q[fifo_rp_q];
  assign head_mask  = fifo_mask_q[fifo_rp_q];

  // Calibration counter; done latches until reset.
  always_comb begin
    calib_cnt_d = calib_cnt_q;
    calib_d     = calib_q;
    if (!calib_q) begin
      calib_cnt_d = calib_cnt_q + 1'b1;
      calib_d     = (calib_cnt_q == CW'(CALIB_CYCLES - 1));
    end
  end

  // Pair write commands with data: FIFO head, bypass, or park.
  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = cmd_idx;
    wr_data    = head_data;
    wr_mask    = head_mask;
    push       = wdf_acc;
    pop        = 1'b0;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    unique case (1'b1)
      pend_q & wdf_acc: begin
        wr_en   = 1'b1;
        wr_idx  = pend_idx_q;
        wr_data = app_wdf_data;
        wr_mask = app_wdf_mask;
        push    = 1'b0;
        pend_d  = 1'b0;
      end
      wr_cmd & ~fifo_empty: begin
        wr_en = 1'b1;
        pop   = 1'b1;
      end
      wr_cmd & fifo_empty & wdf_acc: begin
        wr_en   = 1'b1;
        wr_data = app_wdf_data;
        wr_mask = app_wdf_mask;
        push    = 1'b0;
      end
      wr_cmd & fifo_empty & ~wdf_acc: begin
        pend_d     = 1'b1;
        pend_idx_d = cmd_idx;
      end
      default: ;
    endcase
  end

  // Two-entry write-data FIFO bookkeeping.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_mask_d = fifo_mask_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_data_d[fifo_wp_q] = app_wdf_data;
      fifo_mask_d[fifo_wp_q] = app_wdf_mask;
      fifo_wp_d              = ~fifo_wp_q;
    end
    if (pop) fifo_rp_d = ~fifo_rp_q;
  end

  // RAM read word with write-first forwarding.
  always_comb begin
    rd_word = mem_q[cmd_idx];
    if (wr_en && (wr_idx == cmd_idx)) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wr_mask[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  assign src_v   = {pipe_v_q, rd_cmd};
  assign src_dat = {pipe_dat_q, rd_word};

  // Read return shift register; data stages hold when idle.
  always_comb begin
    pipe_v_d   = '0;
    pipe_dat_d = pipe_dat_q;
    for (int k = 0; k < RL; k++) begin
      pipe_v_d[k] = src_v[k];
      if (src_v[k]) pipe_dat_d[k] = src_dat[k];
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      fifo_data_q <= '0;
      fifo_mask_q <= '0;
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      pipe_v_q    <= '0;
      pipe_dat_q  <= '0;
    end else begin
      calib_cnt_q <= calib_cnt_d;
      calib_q     <= calib_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      fifo_data_q <= fifo_data_d;
      fifo_mask_q <= fifo_mask_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
      pipe_v_q    <= pipe_v_d;
      pipe_dat_q  <= pipe_dat_d;
    end
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge ui_clk) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign app_rd_data         = pipe_dat_q[RL-1];
  assign app_rd_data_valid   = pipe_v_q[RL-1];
  assign app_rd_data_end     = pipe_v_q[RL-1];
  assign init_calib_complete = calib_q;

  logic unused_ok;
  assign unused_ok = ^{app_wdf_end,
                       app_addr[ADDR_WIDTH-1:IW+4],
                       app_addr[3:0]};

endmodule

// File: tb/tb_mig_app_bram_model.sv
// tb_mig_app_bram_model: vector table, hand sequences and a
// read scoreboard against mig_app_bram_model.
module tb_mig_app_bram_model;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int MW  = 16;
  localparam int RL  = 4;
  localparam int CAL = 64;
`ifdef MIG_MODEL_STALL_EN
  localparam int NR = 1000;
`else
  localparam int NR = 200;
`endif

  logic          ui_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = 3'b111;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;

  always #5 ui_clk = ~ui_clk;

  mig_app_bram_model dut (
    .ui_clk              (ui_clk),
    .rst_n               (rst_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    int            dly;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            valid_seen = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] model [1024];

  always @(posedge ui_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  always @(negedge ui_clk) begin
    if (!rst_n) begin
      last_rd = '0;
    end else begin
      chk("rd_end", 128'(app_rd_data_end), 128'(app_rd_data_valid));
      if (app_rd_data_valid) begin
        valid_seen++;
        chk("rd_outstanding", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("rd_data", app_rd_data, mon_e.data);
          chk("rd_latency", 128'(cyc), 128'(mon_e.due));
        end
        last_rd = app_rd_data;
      end else begin
        chk("rd_hold", app_rd_data, last_rd);
      end
    end
  end

`ifdef MIG_MODEL_STALL_EN
  int rdy_low = 0;
  always @(negedge ui_clk)
    if (rst_n && init_calib_complete && !app_rdy) rdy_low++;
`endif

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++)
      if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_cmd_rdy();
    int n = 0;
    while (!app_rdy && n < 400) begin
      @(negedge ui_clk);
      n++;
    end
    chk("cmd_rdy_timeout", 128'(n >= 400), 128'(0));
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    wait_cmd_rdy();
    @(negedge ui_clk);
  endtask

  task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    app_en = 1'b1;
    app_cmd = 3'b001;
    app_addr = a;
    wait_cmd_rdy();
    sb.push_back('{data: e, due: cyc + RL});
    @(negedge ui_clk);
  endtask

  task automatic send_wd(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    while (!app_wdf_rdy && n < 400) begin
      @(negedge ui_clk);
      n++;
    end
    chk("wdf_rdy_timeout", 128'(n >= 400), 128'(0));
    @(negedge ui_clk);
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m, input int dly);
    fork
      begin
        repeat (dly < 0 ? -dly : 0) @(negedge ui_clk);
        send_cmd(3'b000, a);
        app_en = 1'b0;
      end
      begin
        repeat (dly > 0 ? dly : 0) @(negedge ui_clk);
        send_wd(d, m);
      end
    join
    model[a[13:4]] = merge(model[a[13:4]], d, m);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge ui_clk);
      n++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #(900000);
    $display("FAIL watchdog: stuck at cycle %0d, %0d/%0d", cyc, n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          tbl[9];
    int            first;
    int            vs;
    int            idx;
    int            dly;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;

    tbl[0] = '{28'h10, 28'h10, 128'hDEADBEEF, 16'h0000, 0,
               128'hDEADBEEF};
    tbl[1] = '{28'h20, 28'h20, {128{1'b1}}, 16'h0000, 0,
               {128{1'b1}}};
    tbl[2] = '{28'h20, 28'h20, 128'h0, 16'hFFF0, 0,
               {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0}};
    tbl[3] = '{28'h00, 28'h00,
               128'h0123456789ABCDEF_FEDCBA9876543210, 16'h0000, -2,
               128'h0123456789ABCDEF_FEDCBA9876543210};
    tbl[4] = '{28'h40, 28'h40, {8{16'h1111}}, 16'h0000, 1,
               {8{16'h1111}}};
    tbl[5] = '{28'h40, 28'h40, {8{16'h2222}}, 16'h5555, 2,
               {8{16'h2211}}};
    tbl[6] = '{28'h0004050, 28'h50, 128'hCAFE, 16'h0000, 0,
               128'hCAFE};
    tbl[7] = '{28'h000006F, 28'h8000060,
               {64'hBEEF_0000_1234_5678, 64'h0}, 16'h0000, -1,
               {64'hBEEF_0000_1234_5678, 64'h0}};
    tbl[8] = '{28'h70, 28'h70, {16{8'h5A}}, 16'h0000, 0,
               {16{8'h5A}}};

    repeat (3) @(negedge ui_clk);
    chk("rst_calib", 128'(init_calib_complete), 128'(0));
    chk("rst_app_rdy", 128'(app_rdy), 128'(0));
    chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
    chk("rst_valid", 128'(app_rd_data_valid), 128'(0));
    chk("rst_rd_data", app_rd_data, 128'(0));

    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= CAL; i++) begin
      @(negedge ui_clk);
      if (init_calib_complete && first < 0) first = i;
      if (i == CAL - 1) begin
        chk("calib_pre", 128'(init_calib_complete), 128'(0));
        chk("rdy_pre", 128'(app_rdy), 128'(0));
        chk("wdf_rdy_pre", 128'(app_wdf_rdy), 128'(0));
      end
`ifndef MIG_MODEL_STALL_EN
      if (i == CAL) begin
        chk("rdy_at_calib", 128'(app_rdy), 128'(1));
        chk("wdf_rdy_at_calib", 128'(app_wdf_rdy), 128'(1));
      end
`endif
    end
    chk("calib_rise_cycle", 128'(first), 128'(CAL));
    chk("calib_no_valid", 128'(valid_seen), 128'(0));

    for (int i = 0; i < 9; i++) begin
      do_write(tbl[i].waddr, tbl[i].data, tbl[i].mask, tbl[i].dly);
      issue_rd(tbl[i].raddr, tbl[i].exp);
      app_en = 1'b0;
      wait_drain();
    end

    d = 128'h3030_AAAA_5555_0F0F_F0F0_1234_ABCD_0030;
`ifndef MIG_MODEL_STALL_EN
    app_en = 1'b1;
    app_cmd = 3'b000;
    app_addr = 28'h30;
    chk("dly_rdy_pre", 128'(app_rdy), 128'(1));
    @(negedge ui_clk);
    app_en = 1'b0;
    chk("dly_rdy_low0", 128'(app_rdy), 128'(0));
    @(negedge ui_clk);
    chk("dly_rdy_low1", 128'(app_rdy), 128'(0));
    @(negedge ui_clk);
    chk("dly_rdy_low2", 128'(app_rdy), 128'(0));
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = '0;
    chk("dly_wdf_rdy", 128'(app_wdf_rdy), 128'(1));
    @(negedge ui_clk);
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    chk("dly_rdy_back", 128'(app_rdy), 128'(1));
    model[6'h3] = d;
`else
    do_write(28'h30, d, '0, 3);
`endif
    issue_rd(28'h30, d);
    app_en = 1'b0;
    wait_drain();

    send_wd(128'h1111_0080, 16'h0000);
    send_wd(128'h2222_0090, 16'h0000);
    chk("fifo_full", 128'(app_wdf_rdy), 128'(0));
    send_cmd(3'b000, 28'h80);
    send_cmd(3'b000, 28'h90);
    app_en = 1'b0;
    model[8] = 128'h1111_0080;
    model[9] = 128'h2222_0090;
    issue_rd(28'h80, 128'h1111_0080);
    issue_rd(28'h90, 128'h2222_0090);
    app_en = 1'b0;
    wait_drain();

    for (int i = 0; i < 8; i++) issue_rd(AW'(i) << 4, model[i]);
    app_en = 1'b0;
    wait_drain();

    send_wd(128'h5757_57A1E, 16'h0000);
    issue_rd(28'h10, model[1]);
    issue_rd(28'h20, model[2]);
    issue_rd(28'h40, model[4]);
    app_en = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    vs = valid_seen;
    repeat (2) @(negedge ui_clk);
    chk("rst_mid_calib", 128'(init_calib_complete), 128'(0));
    rst_n = 1'b1;
    repeat (CAL + 6) @(negedge ui_clk);
    chk("rst_mid_no_valid", 128'(valid_seen - vs), 128'(0));
    chk("rst_mid_recal", 128'(init_calib_complete), 128'(1));
    d = 128'hF2E5_0070_0000_1111_2222_3333_4444_5555;
    do_write(28'h70, d, '0, 0);
    issue_rd(28'h10, 128'hDEADBEEF);
    issue_rd(28'h40, {8{16'h2211}});
    issue_rd(28'h70, d);
    app_en = 1'b0;
    wait_drain();

    for (int i = 0; i < 16; i++) do_write(AW'(i) << 4, rnd128(), '0, 0);
    for (int i = 0; i < NR; i++) begin
      idx = int'($urandom_range(0, 15));
      a = {14'($urandom), 6'd0, 4'(idx), 4'($urandom)};
      d = rnd128();
      m = 16'($urandom);
      dly = int'($urandom_range(0, 6)) - 3;
      do_write(a, d, m, dly);
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, 15));
        issue_rd(AW'(idx) << 4, model[idx]);
        app_en = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) issue_rd(AW'(i) << 4, model[i]);
    app_en = 1'b0;
    wait_drain();

`ifdef MIG_MODEL_STALL_EN
    chk("stall_rdy_low", 128'(rdy_low >= 100), 128'(1));
`endif

    repeat (3) @(negedge ui_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
